// File: rtl/encode_acc_requant.sv
// encode_acc_requant
//   Accumulates NUM_TAPS signed products from the encoder multiplier,
//   adds a per-group bias, then rounds (half-up), shifts right by SHIFT,
//   optionally applies ReLU and saturates to OUT_WIDTH. The result sits in
//   a one-entry output buffer behind a valid/ready handshake.
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous active-high reset, has priority over ce
//   ce          clock enable; when low all state holds, no handshake completes
//   prod_valid  prod_data valid
//   prod_ready  block accepts prod_data (combinational from out_ready)
//   prod_data   signed product, PROD_WIDTH bits
//   bias        signed bias, sampled with the first product of a group
//   out_valid   out_data holds a result
//   out_ready   consumer accepts out_data
//   out_data    signed requantized result, OUT_WIDTH bits
//   out_sat     result was clipped by saturation (ReLU clipping excluded)
module encode_acc_requant #(
  parameter int PROD_WIDTH = 65,
  parameter int ACC_WIDTH  = 72,
  parameter int BIAS_WIDTH = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int NUM_TAPS   = 9,
  parameter int SHIFT      = 24,
  parameter int RELU       = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         prod_valid,
  output logic                         prod_ready,
  input  logic signed [PROD_WIDTH-1:0] prod_data,
  input  logic signed [BIAS_WIDTH-1:0] bias,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_sat
);

  localparam int CNT_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);

  // Rounding constant and clamp limits, all in ACC_WIDTH+1 bits so the
  // rounding add cannot overflow.
  localparam logic signed [ACC_WIDTH:0] RND = (ACC_WIDTH+1)'(1) << (SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0] OUT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] OUT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // Returns {sat, data}.
  function automatic logic [OUT_WIDTH:0] requant(input logic signed [ACC_WIDTH-1:0] s);
    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] r;
    logic                      sat;
    logic [OUT_WIDTH-1:0]      d;
    ext = {s[ACC_WIDTH-1], s};
    r   = (ext + RND) >>> SHIFT;
    sat = 1'b0;
    if (RELU != 0 && r[ACC_WIDTH]) begin
      r = '0;
    end
    if (r > OUT_MAX) begin
      d   = OUT_MAX[OUT_WIDTH-1:0];
      sat = 1'b1;
    end else if (r < OUT_MIN) begin
      d   = OUT_MIN[OUT_WIDTH-1:0];
      sat = 1'b1;
    end else begin
      d = r[OUT_WIDTH-1:0];
    end
    return {sat, d};
  endfunction

  logic [CNT_W-1:0]            tap_cnt;
  logic signed [ACC_WIDTH-1:0] acc_p0;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] bias_ext;
  logic signed [ACC_WIDTH-1:0] base;
  logic signed [ACC_WIDTH-1:0] sum;
  logic [OUT_WIDTH:0]          rq;
  logic                        last_tap;
  logic                        accept;
  logic                        consume;

  assign last_tap   = (tap_cnt == LAST_TAP);
  // Only the group-completing product stalls on a held, unconsumed result.
  assign prod_ready = !(last_tap && out_valid && !out_ready);
  assign accept     = ce && prod_valid && prod_ready;
  assign consume    = ce && out_valid && out_ready;

  assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
  assign bias_ext = {{(ACC_WIDTH-BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias};
  // First tap starts from the bias instead of the accumulator; this also
  // covers NUM_TAPS==1, where the first tap is the last.
  assign base     = (tap_cnt == '0) ? bias_ext : acc_p0;
  assign sum      = base + prod_ext;
  assign rq       = requant(sum);

  // Stage p0: accumulator / tap counter; result lands in the output buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      tap_cnt   <= '0;
      acc_p0    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (accept) begin
        if (last_tap) begin
          tap_cnt  <= '0;
          out_data <= rq[OUT_WIDTH-1:0];
          out_sat  <= rq[OUT_WIDTH];
        end else begin
          tap_cnt <= tap_cnt + 1'b1;
          acc_p0  <= sum;
        end
      end
      if (accept && last_tap) begin
        out_valid <= 1'b1;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_encode_acc_requant.sv
module tb_encode_acc_requant;

  localparam int ND = 5;

  function automatic int taps_of(input int g);
    case (g)
      0: return 3;
      1: return 1;
      2: return 1;
      3: return 2;
      default: return 9;
    endcase
  endfunction

  function automatic int shift_of(input int g);
    case (g)
      3: return 1;
      4: return 24;
      default: return 4;
    endcase
  endfunction

  function automatic int relu_of(input int g);
    return (g == 2) ? 1 : 0;
  endfunction

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               ce = 1'b1;
  logic signed [64:0] pd = '0;
  logic signed [31:0] bs = '0;
  logic               pv   [ND];
  logic               pr   [ND];
  logic               ov   [ND];
  logic               ordy [ND];
  logic signed [15:0] od   [ND];
  logic               os   [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    encode_acc_requant #(
      .NUM_TAPS(taps_of(g)),
      .SHIFT   (shift_of(g)),
      .RELU    (relu_of(g))
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .ce        (ce),
      .prod_valid(pv[g]),
      .prod_ready(pr[g]),
      .prod_data (pd),
      .bias      (bs),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .out_data  (od[g]),
      .out_sat   (os[g])
    );
  end

  typedef struct {
    int                 id;
    logic signed [15:0] d;
    logic               s;
  } exp_t;

  exp_t               sbq[$];
  int                 ncmp = 0;
  int                 nfail = 0;
  int                 mcnt [ND];
  logic signed [79:0] msum [ND];
  logic               rnd_bp = 1'b0;

  task automatic chk(input string nm, input logic signed [79:0] act, input logic signed [79:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: floor shift plus the bit just below the cut gives half-up rounding.
  function automatic exp_t model(input int k, input logic signed [79:0] s);
    exp_t               e;
    logic signed [79:0] r;
    int                 sh;
    sh  = shift_of(k);
    r   = s >>> sh;
    if (s[sh-1]) r = r + 80'sd1;
    e.id = k;
    e.s  = 1'b0;
    if (relu_of(k) != 0 && r < 0) r = '0;
    if (r > 32767) begin
      r = 32767; e.s = 1'b1;
    end else if (r < -32768) begin
      r = -32768; e.s = 1'b1;
    end
    e.d = r[15:0];
    return e;
  endfunction

  // Scoreboard: expected results pushed on accepted products, popped on consume.
  always @(negedge clk) begin
    if (reset) begin
      sbq.delete();
      for (int k = 0; k < ND; k++) mcnt[k] = 0;
    end else if (ce) begin
      for (int k = 0; k < ND; k++) begin
        if (ov[k] && ordy[k]) begin
          if (sbq.size() == 0) begin
            ncmp++; nfail++;
            $display("FAIL sb_unexpected dut%0d: got %0d expected no output", k, od[k]);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            chk($sformatf("sb_id dut%0d", k), k, e.id);
            chk($sformatf("sb_data dut%0d", k), od[k], e.d);
            chk($sformatf("sb_sat dut%0d", k), os[k], e.s);
          end
        end
        if (pv[k] && pr[k]) begin
          if (mcnt[k] == 0)
            msum[k] = {{48{bs[31]}}, bs} + {{15{pd[64]}}, pd};
          else
            msum[k] = msum[k] + {{15{pd[64]}}, pd};
          mcnt[k]++;
          if (mcnt[k] == taps_of(k)) begin
            sbq.push_back(model(k, msum[k]));
            mcnt[k] = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive one product and return just after the edge that accepted it.
  task automatic put(input int k, input logic signed [64:0] p, input logic signed [31:0] b);
    int n = 0;
    pd = p; bs = b; pv[k] = 1'b1;
    forever begin
      @(negedge clk);
      if (ce && pr[k]) break;
      if (n++ == 40) begin
        ncmp++; nfail++;
        $display("FAIL put_timeout dut%0d: got prod_ready=%0d expected 1", k, pr[k]);
        break;
      end
      @(posedge clk); #1;
      if (rnd_bp) ordy[k] = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    pv[k] = 1'b0;
    if (rnd_bp) ordy[k] = 1'($urandom_range(0, 1));
  endtask

  typedef struct {
    int                 k;
    logic signed [64:0] p;
    logic signed [31:0] b;
    logic signed [15:0] d;
    logic               s;
  } vec_t;

  localparam logic signed [64:0] P40  = 65'sh100_0000_0000;
  localparam logic signed [64:0] PMAX = 65'sh0_FFFF_FFFF_FFFF_FFFF;
  localparam logic signed [64:0] PMIN = 65'sh1_0000_0000_0000_0000;

  initial begin
    vec_t tbl[$];
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[16];
    for (int k = 0; k < ND; k++) begin pv[k] = 1'b0; ordy[k] = 1'b1; end
    tbl[0]  = '{1,  24,   0,      2, 1'b0};
    tbl[1]  = '{1, -24,   0,     -1, 1'b0};
    tbl[2]  = '{1, -25,   0,     -2, 1'b0};
    tbl[3]  = '{1,   7,   0,      0, 1'b0};
    tbl[4]  = '{1,  P40,  0,  32767, 1'b1};
    tbl[5]  = '{1, -P40,  0, -32768, 1'b1};
    tbl[6]  = '{1, 524272, 0, 32767, 1'b0};
    tbl[7]  = '{1, 524280, 0, 32767, 1'b1};
    tbl[8]  = '{1, -524288, 0, -32768, 1'b0};
    tbl[9]  = '{1, -524297, 0, -32768, 1'b1};
    tbl[10] = '{1,   8,   8,      1, 1'b0};
    tbl[11] = '{2, -24,   0,      0, 1'b0};
    tbl[12] = '{2,  24,   0,      2, 1'b0};
    tbl[13] = '{2, -P40,  0,      0, 1'b0};
    tbl[14] = '{2,  P40,  0,  32767, 1'b1};
    tbl[15] = '{2,  -8, -40,      0, 1'b0};

    repeat (3) tick();
    reset = 1'b0;
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("rst_out_valid dut%0d", k), ov[k], 0);
      chk($sformatf("rst_out_data dut%0d", k), od[k], 0);
      chk($sformatf("rst_prod_ready dut%0d", k), pr[k], 1);
    end

    // Basic group, NUM_TAPS=3
    put(0, 16, 0);
    put(0, 32, 0);
    chk("basic_no_early_valid", ov[0], 0);
    put(0, 48, 0);
    chk("basic_valid", ov[0], 1);
    chk("basic_data", od[0], 6);
    chk("basic_sat", os[0], 0);
    tick();
    chk("basic_valid_one_cycle", ov[0], 0);

    // Rounding / ReLU / saturation vectors, NUM_TAPS=1
    for (int i = 0; i < 16; i++) begin
      put(tbl[i].k, tbl[i].p, tbl[i].b);
      chk($sformatf("vec%0d_valid", i), ov[tbl[i].k], 1);
      chk($sformatf("vec%0d_data", i), od[tbl[i].k], tbl[i].d);
      chk($sformatf("vec%0d_sat", i), os[tbl[i].k], tbl[i].s);
    end
    tick();

    // Backpressure, NUM_TAPS=3
    ordy[0] = 1'b0;
    put(0, 16, 0); put(0, 16, 0); put(0, 16, 0);
    chk("bp_res1_valid", ov[0], 1);
    chk("bp_res1_data", od[0], 3);
    put(0, 160, 0);
    put(0, 160, 0);
    pd = 160; pv[0] = 1'b1;
    @(negedge clk);
    chk("bp_stall_ready", pr[0], 0);
    tick();
    @(negedge clk);
    chk("bp_stall_ready2", pr[0], 0);
    chk("bp_hold_data", od[0], 3);
    tick();
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", pr[0], 1);
    tick();
    pv[0] = 1'b0;
    chk("bp_res2_valid", ov[0], 1);
    chk("bp_res2_data", od[0], 30);
    tick();
    chk("bp_res2_consumed", ov[0], 0);

    // Reset mid-group with a held result
    ordy[0] = 1'b0;
    put(0, 16, 0); put(0, 16, 0); put(0, 16, 0);
    put(0, 16, 0); put(0, 16, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_valid", ov[0], 0);
    chk("rstmid_data", od[0], 0);
    chk("rstmid_ready", pr[0], 1);
    ordy[0] = 1'b1;
    put(0, 32, 0);
    put(0, 32, 0);
    chk("rstmid_no_early", ov[0], 0);
    put(0, 32, 0);
    chk("rstmid_res_valid", ov[0], 1);
    chk("rstmid_res_data", od[0], 6);
    tick();

    // Bias sampling and ce, NUM_TAPS=2, SHIFT=1
    pd = 3; bs = 10; pv[3] = 1'b1;
    tick();
    pd = 5; bs = -77; ce = 1'b0;
    tick(); tick();
    chk("ce_no_valid", ov[3], 0);
    ce = 1'b1;
    tick();
    pv[3] = 1'b0;
    chk("ce_res_valid", ov[3], 1);
    chk("ce_res_data", od[3], 9);
    chk("ce_res_sat", os[3], 0);
    ce = 1'b0;
    tick(); tick();
    chk("ce_hold_valid", ov[3], 1);
    chk("ce_hold_data", od[3], 9);
    ce = 1'b1;
    tick();
    chk("ce_consumed", ov[3], 0);

    // Full-range products, NUM_TAPS=9
    for (int i = 0; i < 9; i++) put(4, PMAX, 0);
    chk("full_max_data", od[4], 32767);
    chk("full_max_sat", os[4], 1);
    for (int i = 0; i < 9; i++) put(4, PMIN, 0);
    chk("full_min_data", od[4], -32768);
    chk("full_min_sat", os[4], 1);
    for (int i = 0; i < 4; i++) put(4, PMAX, 0);
    for (int i = 0; i < 4; i++) put(4, PMIN, 0);
    put(4, 65'sd100 <<< 24, 0);
    chk("full_cancel_data", od[4], 100);
    chk("full_cancel_sat", os[4], 0);

    // Random groups with random consumer stalls
    rnd_bp = 1'b1;
    for (int g = 0; g < 6; g++) begin
      logic signed [31:0] b;
      b = 32'($urandom);
      for (int i = 0; i < 9; i++) begin
        logic [63:0] v;
        v = {$urandom, $urandom};
        put(4, {{27{v[37]}}, v[37:0]}, b);
      end
    end
    rnd_bp = 1'b0;
    ordy[4] = 1'b1;
    repeat (5) tick();
    chk("sb_drain", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
